// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU sharing controller.
// Opcodes, latencies and FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;

  localparam logic [3:0] MAX_OPCODE = 4'b1010;

  localparam logic [1:0] BASE_LAT = 2'd1;
  localparam logic [1:0] DIV_LAT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] lat_of(
    input logic [3:0] op
  );
    return (op == OP_DIV) ? DIV_LAT : BASE_LAT;
  endfunction

  function automatic logic legal_op(
    input logic [3:0] op
  );
    return op <= MAX_OPCODE;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Per-requester request/response channel.
// master = client side, slave = controller side.
interface alu_share_ctrl_if;
  logic        valid;
  logic        ready;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        err;

  modport master (
    output valid, opcode, a, b, resp_ready,
    input  ready, resp_valid, result, err
  );

  modport slave (
    input  valid, opcode, a, b, resp_ready,
    output ready, resp_valid, result, err
  );
endinterface

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin arbiter.
// Pointer moves past the winner on accept.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  // single valid wins outright; pointer breaks ties
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = 2'b00;
    endcase
  end

  // after a grant, priority goes to the other side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= 1'b0;
    else if (accept)
      ptr <= grant[0];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters.
// Round-robin, one op in flight, tagged responses.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_share_ctrl_if.slave req0,
  alu_share_ctrl_if.slave req1,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        busy
);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  cnt;
  logic        owner;
  logic [1:0]  grant;
  logic        accept;
  logic        legal;
  logic        own_ready;
  logic [3:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [31:0] res0;
  logic [31:0] res1;
  logic        err0;
  logic        err1;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1.valid, req0.valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept = (state == IDLE) && (grant != 2'b00);

  assign sel_op = grant[1] ? req1.opcode : req0.opcode;
  assign sel_a  = grant[1] ? req1.a : req0.a;
  assign sel_b  = grant[1] ? req1.b : req0.b;
  assign legal  = legal_op(sel_op);

  assign own_ready = owner ? req1.resp_ready
                           : req0.resp_ready;

  assign req0.ready = accept & grant[0];
  assign req1.ready = accept & grant[1];

  assign req0.resp_valid = (state == RESP) & ~owner;
  assign req1.resp_valid = (state == RESP) & owner;
  assign req0.result     = res0;
  assign req1.result     = res1;
  assign req0.err        = err0;
  assign req1.err        = err1;

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state: illegal ops skip the ALU entirely
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = legal ? EXEC : RESP;
      EXEC: if (cnt == 2'd0)
              state_nx = RESP;
      RESP: if (own_ready)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, latency counter, response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 2'd0;
      owner      <= 1'b0;
      alu_opcode <= 4'd0;
      alu_a      <= 16'd0;
      alu_b      <= 16'd0;
      res0       <= 32'd0;
      res1       <= 32'd0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          owner <= grant[1];
          if (legal) begin
            alu_opcode <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            cnt        <= lat_of(sel_op);
          end else if (grant[1]) begin
            res1 <= 32'd0;
            err1 <= 1'b1;
          end else begin
            res0 <= 32'd0;
            err0 <= 1'b1;
          end
        end
        EXEC: if (cnt != 2'd0) begin
          cnt <= cnt - 2'd1;
        end else if (owner) begin
          res1 <= alu_result;
          err1 <= 1'b0;
        end else begin
          res0 <= alu_result;
          err0 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a behavioural ALU.
// Vector table, directed corners, random traffic.
`timescale 1ns/1ps
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] div_q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl_if r0 ();
  alu_share_ctrl_if r1 ();

  alu_share_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (r0.slave),
    .req1       (r1.slave),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] alu_fn(
    input logic [3:0] op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    int x, y, r;
    x = int'($signed(a));
    y = int'($signed(b));
    case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_MUL: r = x * y;
      OP_DIV: r = (y == 0) ? 0 : x / y;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_NOT: r = ~x;
      OP_NEG: r = -x;
      OP_INC: r = x + 1;
      OP_DEC: r = x - 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  // ALU: one-cycle result register, division one stage deeper
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result <= 32'd0;
      div_q      <= 32'd0;
    end else if (alu_opcode == OP_DIV) begin
      div_q      <= alu_fn(alu_opcode, alu_a, alu_b);
      alu_result <= div_q;
    end else begin
      alu_result <= alu_fn(alu_opcode, alu_a, alu_b);
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic pick(input int w);
    case (w)
      0: return r0.ready;
      1: return r1.ready;
      2: return r0.resp_valid;
      default: return r1.resp_valid;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm);
    int i;
    logic hit;
    i = 0;
    hit = pick(w);
    while (!hit && i < 30) begin
      @(negedge clk);
      #2;
      i++;
      hit = pick(w);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout actual=0 required=1", nm);
    end
  endtask

  task automatic drv(input int n, input logic v,
                     input logic [3:0] op,
                     input logic [15:0] a,
                     input logic [15:0] b);
    if (n == 0) begin
      r0.valid = v; r0.opcode = op;
      r0.a = a; r0.b = b;
    end else begin
      r1.valid = v; r1.opcode = op;
      r1.a = a; r1.b = b;
    end
  endtask

  // Reference model: one op outstanding, due time from
  // the latency rule, winner alternates on contention.
  initial begin : mon
    int k;
    int due;
    logic ov, on, lo, ee, n;
    logic [31:0] er;
    logic [3:0] xo, op;
    logic [15:0] xa, xb, pa, pb;
    logic [1:0] v, rd, exp_rd, exp_rv;
    k = 0; due = 0; ov = 0; on = 0; lo = 1;
    ee = 0; er = 0; xo = 0; xa = 0; xb = 0;
    forever begin
      @(negedge clk);
      #3;
      k++;
      if (!reset) begin
        ov = 0; lo = 1; xo = 0; xa = 0; xb = 0;
        chk("rst_flags",
            {busy, r0.resp_valid, r1.resp_valid,
             r0.err, r1.err, alu_opcode}, 0);
        chk("rst_results", {r0.result, r1.result}, 0);
        chk("rst_operands", {alu_a, alu_b}, 0);
        continue;
      end
      v  = {r1.valid, r0.valid};
      rd = {r1.ready, r0.ready};
      if (ov)
        exp_rd = 2'b00;
      else if (v == 2'b11)
        exp_rd = lo ? 2'b01 : 2'b10;
      else
        exp_rd = v;
      chk("m_ready", rd, exp_rd);
      chk("m_busy", busy, ov);
      chk("m_alu", {alu_opcode, alu_a, alu_b},
          {xo, xa, xb});
      exp_rv = (ov && k >= due) ? (on ? 2'b10 : 2'b01)
                                : 2'b00;
      chk("m_resp_valid", {r1.resp_valid, r0.resp_valid},
          exp_rv);
      if (ov && k >= due) begin
        chk("m_result", on ? r1.result : r0.result, er);
        chk("m_err", on ? r1.err : r0.err, ee);
        if (on ? r1.resp_ready : r0.resp_ready)
          ov = 0;
      end else if (!ov && exp_rd != 2'b00) begin
        n  = exp_rd[1];
        op = n ? r1.opcode : r0.opcode;
        pa = n ? r1.a : r0.a;
        pb = n ? r1.b : r0.b;
        ov = 1; on = n; lo = n;
        if (op <= 4'd10) begin
          due = k + ((op == 4'd3) ? 4 : 3);
          er = alu_fn(op, pa, pb);
          ee = 0;
          xo = op; xa = pa; xb = pb;
        end else begin
          due = k + 1;
          er = 0;
          ee = 1;
        end
      end
    end
  end

  typedef struct {
    logic        n;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic run_vec(input vec_t vc);
    int lat;
    logic got;
    int w;
    w = vc.n ? 3 : 2;
    @(negedge clk);
    drv(int'(vc.n), 1'b1, vc.op, vc.a, vc.b);
    #2;
    wait_for(vc.n ? 1 : 0, "vec_accept");
    @(negedge clk);
    drv(int'(vc.n), 1'b0, vc.op, vc.a, vc.b);
    #2;
    lat = 1;
    got = pick(w);
    while (!got && lat < 20) begin
      @(negedge clk);
      #2;
      lat++;
      got = pick(w);
    end
    chk("vec_latency", lat, vc.lat);
    chk("vec_result", vc.n ? r1.result : r0.result, vc.res);
    chk("vec_err", vc.n ? r1.err : r0.err, vc.err);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1);
  end

  initial begin : main
    logic [3:0] prev_op;
    logic [1:0] pv, acc;
    logic [3:0] rop[2];
    logic [15:0] ra[2], rb[2];
    int dual;
    int oq[$];
    logic [31:0] rq[$];

    tbl[0] = '{1'b0, 4'd0,  16'hFFF6, 16'hFFF5,
               32'hFFFFFFEB, 1'b0, 3};
    tbl[1] = '{1'b1, 4'd3,  16'd25,   16'd5,
               32'd5,        1'b0, 4};
    tbl[2] = '{1'b0, 4'hF,  16'd1,    16'd2,
               32'd0,        1'b1, 1};
    tbl[3] = '{1'b1, 4'd1,  16'd9,    16'd4,
               32'd5,        1'b0, 3};
    tbl[4] = '{1'b0, 4'd2,  16'd300,  16'd300,
               32'h00015F90, 1'b0, 3};
    tbl[5] = '{1'b1, 4'd4,  16'h00F0, 16'h0FF0,
               32'h000000F0, 1'b0, 3};
    tbl[6] = '{1'b0, 4'd6,  16'h000A, 16'hFFFF,
               32'hFFFFFFF5, 1'b0, 3};
    tbl[7] = '{1'b1, 4'hB,  16'd7,    16'd7,
               32'd0,        1'b1, 1};
    tbl[8] = '{1'b0, 4'hA,  16'd0,    16'd0,
               32'hFFFFFFFF, 1'b0, 3};
    tbl[9] = '{1'b1, 4'd3,  16'hFF9C, 16'd7,
               32'hFFFFFFF2, 1'b0, 4};

    reset = 1'b0;
    drv(0, 1'b0, 4'd0, 16'd0, 16'd0);
    drv(1, 1'b0, 4'd0, 16'd0, 16'd0);
    r0.resp_ready = 1'b0;
    r1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy", busy, 1'b0);
    chk("reset_resp", {r0.resp_valid, r1.resp_valid}, 0);

    // contention straight out of reset
    @(negedge clk);
    reset = 1'b1;
    drv(0, 1'b1, 4'd0, 16'd1, 16'd1);
    drv(1, 1'b1, 4'd1, 16'd9, 16'd4);
    r0.resp_ready = 1'b1;
    r1.resp_ready = 1'b1;
    dual = 0;
    for (int c = 0; c < 40 && rq.size() < 3; c++) begin
      #2;
      if (r0.ready && r1.ready) dual++;
      if (r0.resp_valid) begin
        oq.push_back(0); rq.push_back(r0.result);
      end
      if (r1.resp_valid) begin
        oq.push_back(1); rq.push_back(r1.result);
      end
      @(negedge clk);
    end
    drv(0, 1'b0, 4'd0, 16'd1, 16'd1);
    drv(1, 1'b0, 4'd1, 16'd9, 16'd4);
    while (rq.size() < 3) begin
      oq.push_back(9); rq.push_back(32'hDEAD);
    end
    chk("alt_dual_ready", dual, 0);
    chk("alt_owner0", oq[0], 0);
    chk("alt_owner1", oq[1], 1);
    chk("alt_owner2", oq[2], 0);
    chk("alt_result0", rq[0], 2);
    chk("alt_result1", rq[1], 5);
    chk("alt_result2", rq[2], 2);

    // single-requester vectors
    prev_op = 4'd0;
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i]);
      if (tbl[i].err)
        chk("illegal_keeps_alu_op", alu_opcode, prev_op);
      else
        prev_op = tbl[i].op;
    end

    // held response under backpressure
    @(negedge clk);
    r0.resp_ready = 1'b0;
    drv(0, 1'b1, 4'd6, 16'h000A, 16'hFFFF);
    #2;
    wait_for(0, "bp_accept");
    @(negedge clk);
    drv(0, 1'b0, 4'd6, 16'h000A, 16'hFFFF);
    drv(1, 1'b1, 4'd0, 16'd3, 16'd4);
    #2;
    wait_for(2, "bp_resp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("bp_hold_result", r0.result, 32'hFFFFFFF5);
      chk("bp_hold_valid", r0.resp_valid, 1'b1);
      chk("bp_r1_blocked", r1.ready, 1'b0);
    end
    @(negedge clk);
    r0.resp_ready = 1'b1;
    #2;
    chk("bp_hs_r1_blocked", r1.ready, 1'b0);
    @(negedge clk);
    #2;
    chk("bp_next_r1_ready", r1.ready, 1'b1);
    chk("bp_next_r0_valid", r0.resp_valid, 1'b0);
    @(negedge clk);
    drv(1, 1'b0, 4'd0, 16'd3, 16'd4);
    #2;
    wait_for(3, "bp_r1_resp");
    chk("bp_r1_result", r1.result, 32'd7);

    // reset in the middle of a division
    @(negedge clk);
    drv(0, 1'b1, 4'd3, 16'd25, 16'd5);
    #2;
    wait_for(0, "rst_div_accept");
    @(negedge clk);
    drv(0, 1'b0, 4'd3, 16'd25, 16'd5);
    #5;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    chk("async_rst_resp",
        {r0.resp_valid, r1.resp_valid, r0.result}, 0);
    @(negedge clk);
    drv(0, 1'b1, 4'd0, 16'd1, 16'd1);
    drv(1, 1'b1, 4'd1, 16'd9, 16'd4);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("post_rst_grant", {r1.ready, r0.ready}, 2'b01);
    @(negedge clk);
    drv(0, 1'b0, 4'd0, 16'd1, 16'd1);
    #2;
    wait_for(2, "post_rst_r0_resp");
    chk("post_rst_r0_result", r0.result, 32'd2);
    chk("post_rst_r0_err", r0.err, 1'b0);
    wait_for(1, "post_rst_r1_accept");
    @(negedge clk);
    drv(1, 1'b0, 4'd1, 16'd9, 16'd4);
    #2;
    wait_for(3, "post_rst_r1_resp");
    chk("post_rst_r1_result", r1.result, 32'd5);

    // random traffic, checked by the model
    pv = 2'b00;
    acc = 2'b00;
    for (int n = 0; n < 2; n++) begin
      rop[n] = 4'd0; ra[n] = 16'd0; rb[n] = 16'd0;
    end
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (acc[n])
          pv[n] = 1'b0;
        else if (pv[n] && $urandom_range(7) == 0)
          pv[n] = 1'b0;
        else if (!pv[n] && $urandom_range(2) == 0) begin
          pv[n]  = 1'b1;
          rop[n] = 4'($urandom_range(15));
          ra[n]  = 16'($urandom);
          rb[n]  = 16'($urandom);
        end
        drv(n, pv[n], rop[n], ra[n], rb[n]);
      end
      r0.resp_ready = 1'($urandom_range(1));
      r1.resp_ready = 1'($urandom_range(1));
      #2;
      acc = {r1.ready, r0.ready};
    end
    @(negedge clk);
    drv(0, 1'b0, 4'd0, 16'd0, 16'd0);
    drv(1, 1'b0, 4'd0, 16'd0, 16'd0);
    r0.resp_ready = 1'b1;
    r1.resp_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("drain_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
